// File: rtl/fifo_pkg.sv
// Shared pointer-coding helpers for the async FIFO read and write sides.
// Contents:
//   bin2gray()  binary -> reflected Gray
//   gray2bin()  reflected Gray -> binary
// Both work on a 32-bit container. Callers zero-extend narrower pointers
// and truncate the result, so one pair of functions serves every pointer
// width up to 32 bits. Zero-extension is safe because zero upper bits
// leave every prefix XOR used by gray2bin unchanged.
package fifo_pkg;

    localparam int PTR_MAX_W = 32;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b = g;
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer bus.
// The source changes at most one bit per source clock, so the captured
// value is always either the old or the new pointer.
// Ports:
//   clk    in   1   destination clock
//   reset  in   1   asynchronous, active-high; clears every stage to 0
//   d      in   W   Gray bus from the foreign clock domain
//   q      out  W   synchronised bus, STAGES destination edges late
module gray_ptr_sync #(
    parameter int W      = 5,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stg [STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer and flag controller for the UART <-> ALU async FIFO.
// This block synchronises the write-domain Gray pointer and keeps the
// binary/Gray read pointer. It drives registered empty, almost_empty and
// level outputs. Each pointer carries one wrap bit, so all DEPTH entries
// are usable.
// Optional feature macro: FIFO_RD_UNDERFLOW_EN adds a sticky underflow flag.
// Ports:
//   clk           in   1         read-domain clock
//   reset         in   1         asynchronous, active-high
//   read          in   1         read request, honoured only while not empty
//   gray_wr_ptr   in   ADDR_W+1  Gray write pointer (write clock domain)
//   rd_addr       out  ADDR_W    RAM read address
//   gray_rd_ptr   out  ADDR_W+1  registered Gray read pointer to write side
//   empty         out  1         registered, no readable entry
//   almost_empty  out  1         registered, level <= AE_THRESH
//   level         out  ADDR_W+1  registered entry count 0..DEPTH
//   underflow     out  1         sticky read-while-empty (FIFO_RD_UNDERFLOW_EN only)
module fifo_rd_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic [ADDR_W:0]   gray_wr_ptr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   gray_rd_ptr,
    output logic              empty,
    output logic              almost_empty,
`ifdef FIFO_RD_UNDERFLOW_EN
    output logic [ADDR_W:0]   level,
    output logic              underflow
`else
    output logic [ADDR_W:0]   level
`endif
);

    localparam int            PW   = ADDR_W + 1;
    localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

    logic [PW-1:0] wr_gray_s;
    logic [PW-1:0] wr_bin_s;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_nxt;
    logic [PW-1:0] rd_gray_nxt;
    logic [PW-1:0] level_nxt;
    logic          rd_inc;

    gray_ptr_sync #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_wr_sync (
        .clk   (clk),
        .reset (reset),
        .d     (gray_wr_ptr),
        .q     (wr_gray_s)
    );

    assign wr_bin_s = PW'(gray2bin(32'(wr_gray_s)));

    // The flags are computed from the next pointer. On the final read, empty
    // therefore rises on the same edge the pointer advances.
    always_comb begin
        rd_inc      = read & ~empty;
        rd_bin_nxt  = rd_bin + PW'(rd_inc);
        rd_gray_nxt = PW'(bin2gray(32'(rd_bin_nxt)));
        level_nxt   = wr_bin_s - rd_bin_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_bin       <= '0;
            gray_rd_ptr  <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            level        <= '0;
        end else begin
            rd_bin       <= rd_bin_nxt;
            gray_rd_ptr  <= rd_gray_nxt;
            empty        <= (rd_gray_nxt == wr_gray_s);
            almost_empty <= (level_nxt <= AE_T);
            level        <= level_nxt;
        end
    end

    assign rd_addr = rd_bin[ADDR_W-1:0];

`ifdef FIFO_RD_UNDERFLOW_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflow <= 1'b0;
        end else if (read && empty) begin
            underflow <= 1'b1;
        end
    end
`endif

endmodule
